// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and rotate helper for the round-robin arbiter
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] rot_right(input logic [N_REQ-1:0] vec, input logic [ID_W-1:0] ptr);
    logic [2*N_REQ-1:0] d;
    d = {vec, vec} >> ptr;
    return d[N_REQ-1:0];
  endfunction
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: index of the lowest set bit of an 8-bit vector, gated by en
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic             en,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);
  // scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (en && vec[i]) idx = ID_W'(i);
    valid = en && |vec;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with done/withdraw/timeout release
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);
  state_t state;
  logic [ID_W-1:0] ptr, idx, winner;
  logic [7:0] hold_cnt;
  logic found, release_now;
  prio_enc8 u_enc (
    .vec(rot_right(req, ptr)),
    .en(state == IDLE),
    .idx(idx),
    .valid(found)
  );
  // undo the rotation and decide whether the current owner gives up the resource
  always_comb begin
    winner = idx + ptr;
    release_now = done || !req[gnt_id] || hold_cnt == 8'(MAX_HOLD);
  end
  // grant/release state machine; every output is registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      timeout <= 1'b0;
      if (found) begin
        state <= GRANT;
        gnt <= N_REQ'(1) << winner;
        gnt_id <= winner;
        gnt_valid <= 1'b1;
        hold_cnt <= 8'd1;
      end
    end else if (release_now) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      timeout <= !done && req[gnt_id];
      ptr <= gnt_id + 3'd1;
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: randomized and directed scoreboard check of rr_arbiter8 against a queue-free behavioural model
module tb_rr_arbiter8;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic gnt_valid, timeout;
  int passed = 0;
  int total = 0;
  int w = 0;
  logic [12:0] exp_q[$];
  int m_owner = -1;
  int m_ptr = 0;
  int m_hold = 0;
  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid),
    .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] model_step(input logic [7:0] r, input logic d);
    logic to;
    logic [12:0] e;
    to = 1'b0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || m_hold == MH) begin
        to = !d && r[m_owner];
        m_ptr = (m_owner + 1) % 8;
        m_owner = -1;
      end else m_hold++;
    end else begin
      for (int k = 0; k < 8; k++)
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_hold = 1;
          break;
        end
    end
    e = (m_owner < 0) ? 13'd0 : {8'(1 << m_owner), 3'(m_owner), 1'b1, 1'b0};
    e[0] = to;
    return e;
  endfunction
  task automatic step(input logic [7:0] r, input logic d);
    req = r;
    done = d;
    exp_q.push_back(model_step(r, d));
    @(negedge clk);
    #1;
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_owner = -1;
    m_ptr = 0;
    m_hold = 0;
    exp_q.push_back(13'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      total++;
      if ({gnt, gnt_id, gnt_valid, timeout} === e) passed++;
      else $display("FAIL outputs t=%0t: got gnt=%h id=%0d v=%b to=%b, required gnt=%h id=%0d v=%b to=%b",
                    $time, gnt, gnt_id, gnt_valid, timeout, e[12:5], e[4:2], e[1], e[0]);
    end
  end
  initial begin
    exp_q.push_back(13'd0);
    @(negedge clk);
    #1;
    total++;
    if ({gnt, gnt_id, gnt_valid, timeout} === 13'd0) passed++;
    else $display("FAIL reset state t=%0t: gnt=%h id=%0d v=%b to=%b", $time, gnt, gnt_id, gnt_valid, timeout);
    rst = 1'b0;
    step(8'h01, 1'b0);
    step(8'h01, 1'b1);
    step(8'h00, 1'b0);
    step(8'h81, 1'b0);
    step(8'h81, 1'b1);
    step(8'h81, 1'b0);
    step(8'h81, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
    end
    for (int i = 0; i < 7; i++) step(8'h04, 1'b0);
    step(8'h04, 1'b1);
    step(8'h28, 1'b0);
    step(8'h28, 1'b0);
    step(8'h20, 1'b0);
    step(8'h20, 1'b0);
    step(8'h20, 1'b1);
    step(8'h03, 1'b0);
    step(8'h03, 1'b0);
    async_reset();
    step(8'h03, 1'b0);
    step(8'h03, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(($urandom & $urandom) | 8'h01 << $urandom_range(0, 7)),
           $urandom_range(0, 4) == 0);
    end
    do begin
      step(8'h40, 1'b0);
      w++;
    end while (!gnt[6] && w < 7 * (MH + 1) + 2);
    total++;
    if (gnt[6]) passed++;
    else $display("FAIL expired wait t=%0t: requester 6 not granted after %0d cycles", $time, w);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
